// File: rtl/lsu_master.sv
// Load/store initiator: turns pipeline MEM requests into byte-enabled word bus
// transactions and returns extended load data or an error flag.
module lsu_master #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t             state;
    logic               lat_we;
    logic [1:0]         lat_size;
    logic               lat_sext;
    logic [1:0]         lat_lane;
    logic [CNT_W-1:0]   wait_cnt;

    logic               bad_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [31:0]        ext_c;
    logic [15:0]        half_c;
    logic [7:0]         byte_c;

    // Decode incoming request: alignment check, byte enables, lane replication.
    always_comb begin
        bad_c   = 1'b0;
        be_c    = 4'b0000;
        wdata_c = 32'd0;
        case (req_size)
            SZ_WORD: begin
                bad_c   = (req_addr[1:0] != 2'b00);
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
            SZ_HALF: begin
                bad_c   = req_addr[0];
                be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            SZ_BYTE: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            default: bad_c = 1'b1;
        endcase
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        half_c = lat_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lat_lane)
            2'd0:    byte_c = bus_rdata[7:0];
            2'd1:    byte_c = bus_rdata[15:8];
            2'd2:    byte_c = bus_rdata[23:16];
            default: byte_c = bus_rdata[31:24];
        endcase
        case (lat_size)
            SZ_HALF: ext_c = {{16{lat_sext & half_c[15]}}, half_c};
            SZ_BYTE: ext_c = {{24{lat_sext & byte_c[7]}}, byte_c};
            default: ext_c = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_be     <= 4'b0000;
            bus_wdata  <= 32'd0;
            lat_we     <= 1'b0;
            lat_size   <= 2'd0;
            lat_sext   <= 1'b0;
            lat_lane   <= 2'd0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_size  <= req_size;
                        lat_sext  <= req_sext;
                        lat_lane  <= req_addr[1:0];
                        wait_cnt  <= '0;
                        if (bad_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= req_we;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= be_c;
                            bus_wdata <= req_we ? wdata_c : 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'd0;
                        bus_be    <= 4'b0000;
                        bus_wdata <= 32'd0;
                        if (lat_we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'd0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ext_c;
                    end else if (wait_cnt + CNT_W'(1) == CNT_W'(MAX_WAIT)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
